aes_dec_iterative: RTL and testbench
====================================

// Module: aes_dec_iterative
// PURPOSE
//  Iterative AES-128 inverse cipher: one ciphertext block in, one plaintext block out, one round per clock.
//  Decrypt-side counterpart of the encrypt round datapath; sits between the block-cipher front end and the round-key store.
//  Requests pre-expanded round keys by index, from key 10 down to key 0.
//  Valid/ready handshakes on input and output; one block in flight.
// PARAMETERS
//  NR        10  number of cipher rounds; only 10 (AES-128) is supported
//  RK_IDX_W  4   width of round-key index
// PORTS
//  clk        in   1         clock; all state on rising edge
//  rst_n      in   1         asynchronous, active-low reset
//  in_valid   in   1         ciphertext valid
//  in_ready   out  1         core can accept a block
//  in_data    in   128       ciphertext, byte 0 in [127:120]
//  rk_idx     out  RK_IDX_W  round-key index requested this cycle
//  rk_data    in   128       round key for rk_idx, combinational same-cycle return
//  out_valid  out  1         plaintext valid
//  out_ready  in   1         sink accepts plaintext
//  out_data   out  128       plaintext, byte 0 in [127:120]
//  busy       out  1         high from the accept edge until the output handshake completes
// BEHAVIOUR
//  - Reset (async assert): FSM=IDLE, round counter=0, state reg=0. in_ready=1 once out of reset; out_valid=0, busy=0, out_data=0, rk_idx=NR.
//  - States: IDLE -> ROUND -> DONE -> IDLE.
//  - IDLE: in_ready=1, rk_idx=NR. On in_valid&in_ready: state <= in_data ^ rk_data (rk10), cnt <= NR-1, go ROUND.
//  - ROUND: rk_idx=cnt. state <= InvShiftRows -> InvSubBytes -> AddRoundKey(rk_data) -> InvMixColumns.
//    When cnt==0 (final), InvMixColumns is skipped and the FSM goes to DONE; otherwise cnt decrements.
//  - DONE: out_valid=1, out_data=state. Holds stable until out_ready. On out_valid&out_ready go IDLE.
//  - Latency: out_valid rises on the 10th rising edge after the accept edge.
//    Minimum spacing: 12 cycles per block, because in_ready is low in ROUND and DONE.
//  - in_valid in ROUND/DONE is ignored. in_data is not sampled and no assertion fires.
//  - out_ready while not in DONE has no effect.
//  - Reset mid-round or mid-DONE: block discarded, no out_valid pulse, IDLE on deassert.
//  - rk_idx is valid in every state; the key store must return the key in the same cycle.
//  - All byte ops are GF(2^8) with poly 0x11B. InvMixColumns coefficients are {0e,0b,0d,09}.
// CONFIGURATION
//  AES_DEC_ZEROIZE_EN defined: on the output handshake edge, state reg <= 0. out_data is forced to 0 whenever out_valid=0.
//  AES_DEC_ZEROIZE_EN undefined: state reg retains the last plaintext after the handshake. out_data=state in all states.
// STRUCTURE
//  Shared package aes_pkg holds:
//   - inverse S-box table function and gf_mul helpers (xtime, mul 09/0b/0d/0e)
//   - constants AES_NR=10 and AES_BLK_W=128
//   - FSM state enum (IDLE, ROUND, DONE)
//  One sub-module: aes_inv_round_logic (state_in, round_key, is_final -> state_out).
//  It is purely combinational; this block holds only the FSM, counter and state register.
// TESTING
//  1. FIPS-197 C.1: key 000102..0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff.
//     out_valid rises on the 10th edge after accept.
//  2. FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734.
//  3. Backpressure: hold out_ready=0 for 20 cycles in DONE. out_data stays stable, in_ready=0, and a new in_valid is ignored.
//     Releasing out_ready gives exactly one handshake.
//  4. rk_idx sequence check: values 10,9,...,0, one per cycle, starting at the accept cycle.
//  5. Reset asserted at round 5: out_valid never pulses. After release, in_ready=1 and a fresh C.1 block decrypts correctly.
//  6. Back-to-back: in_valid held high with 8 random blocks. Each result matches the encrypt model's inverse.
//     With AES_DEC_ZEROIZE_EN, out_data=0 between handshakes.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, FSM states, inverse S-box and GF(2^8) helpers
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_BLK_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_fsm_e;

  // Entry x lives at bits [2047-8x -: 8]
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    int idx;
    idx = 2047 - 8 * int'(x);
    return INV_SBOX_TBL[idx -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul09(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul0b(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] mul0d(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul0e(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Column bytes a0..a3 are packed MSB-first
  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3),
            mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3),
            mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3),
            mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3)};
  endfunction

endpackage

// File: rtl/aes_inv_round_logic.sv
// rtl/aes_inv_round_logic.sv - combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns
module aes_inv_round_logic
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] state_in,
  input  logic [AES_BLK_W-1:0] round_key,
  input  logic                 is_final,
  output logic [AES_BLK_W-1:0] state_out
);

  logic [AES_BLK_W-1:0] shifted;
  logic [AES_BLK_W-1:0] subbed;
  logic [AES_BLK_W-1:0] keyed;
  logic [AES_BLK_W-1:0] mixed;

  always_comb begin
    shifted = '0;
    subbed  = '0;
    mixed   = '0;
    // Byte b sits at row b%4, column b/4; row r rotates right by r
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127 - 8 * (4 * c + r) -: 8] = state_in[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8];
      end
    end
    for (int b = 0; b < 16; b++) begin
      subbed[127 - 8 * b -: 8] = inv_sbox(shifted[127 - 8 * b -: 8]);
    end
    keyed = subbed ^ round_key;
    for (int c = 0; c < 4; c++) begin
      mixed[127 - 32 * c -: 32] = inv_mix_column(keyed[127 - 32 * c -: 32]);
    end
    state_out = is_final ? keyed : mixed;
  end

endmodule

// File: rtl/aes_dec_iterative.sv
// rtl/aes_dec_iterative.sv - iterative AES-128 inverse cipher, one round per clock
// Optional AES_DEC_ZEROIZE_EN: clear state on output handshake and mask out_data while not valid.
module aes_dec_iterative
  import aes_pkg::*;
#(
  parameter int NR       = AES_NR,
  parameter int RK_IDX_W = 4
)
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [127:0]         in_data,
  output logic [RK_IDX_W-1:0]  rk_idx,
  input  logic [127:0]         rk_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [127:0]         out_data,
  output logic                 busy
);

  aes_fsm_e              fsm_q, fsm_d;
  logic [RK_IDX_W-1:0]   cnt_q, cnt_d;
  logic [AES_BLK_W-1:0]  state_q, state_d;
  logic [AES_BLK_W-1:0]  round_out;

  aes_inv_round_logic u_round (
    .state_in  (state_q),
    .round_key (rk_data),
    .is_final  (cnt_q == '0),
    .state_out (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      cnt_q   <= '0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    rk_idx    = cnt_q;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        rk_idx   = RK_IDX_W'(NR);
        if (in_valid) begin
          state_d = in_data ^ rk_data;
          cnt_d   = RK_IDX_W'(NR - 1);
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = round_out;
        if (cnt_q == '0) begin
          fsm_d = DONE;
        end else begin
          cnt_d = cnt_q - RK_IDX_W'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_d = IDLE;
`ifdef AES_DEC_ZEROIZE_EN
          state_d = '0;
`endif
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

`ifdef AES_DEC_ZEROIZE_EN
  assign out_data = out_valid ? state_q : '0;
`else
  assign out_data = state_q;
`endif

endmodule

// File: tb/tb_aes_dec_iterative.sv
// tb/tb_aes_dec_iterative.sv - self-checking bench: FIPS vectors, backpressure, reset, random blocks vs encrypt model
module tb_aes_dec_iterative;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [127:0] rk [0:10];
  logic [7:0]   sbox [256];

  aes_dec_iterative dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb rk_data = (rk_idx <= 4'd10) ? rk[rk_idx] : 128'd0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  // Forward cipher over the current key schedule
  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] res;
    for (int b = 0; b < 16; b++) s[b] = pt[127 - 8 * b -: 8] ^ rk[0][127 - 8 * b -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int b = 0; b < 16; b++) t[b] = sbox[s[b]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s[4 * c + rr] = t[4 * ((c + rr) % 4) + rr];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4 * c]; a1 = s[4 * c + 1]; a2 = s[4 * c + 2]; a3 = s[4 * c + 3];
          s[4 * c]     = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
          s[4 * c + 1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
          s[4 * c + 2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
          s[4 * c + 3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
        end
      end
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ rk[r][127 - 8 * b -: 8];
    end
    for (int b = 0; b < 16; b++) res[127 - 8 * b -: 8] = s[b];
    return res;
  endfunction

  function automatic logic [127:0] post_hs(input logic [127:0] pt);
`ifdef AES_DEC_ZEROIZE_EN
    return 128'd0;
`else
    return pt;
`endif
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk({tag, "_in_ready"}, 128'(in_ready), 128'd1);
  endtask

  task automatic do_block(input string tag, input logic [127:0] ct, input logic [127:0] pt, input int hold);
    int n;
    in_data = ct; in_valid = 1'b1; out_ready = 1'b0;
    wait_ready(tag);
    chk({tag, "_rk_accept"}, 128'(rk_idx), 128'd10);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = {$urandom, $urandom, $urandom, $urandom};
    chk({tag, "_busy"}, 128'(busy), 128'd1);
    n = 0;
    while (!out_valid && n < 30) begin
      if (n < 10) chk({tag, "_rk_seq"}, 128'(rk_idx), 128'(9 - n));
      @(posedge clk); #1; n++;
    end
    chk({tag, "_latency"}, 128'(n), 128'd10);
    chk({tag, "_data"}, out_data, pt);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 128'(out_valid), 128'd1);
      chk({tag, "_hold_data"}, out_data, pt);
      chk({tag, "_hold_in_ready"}, 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_hs_valid"}, 128'(out_valid), 128'd0);
    chk({tag, "_hs_in_ready"}, 128'(in_ready), 128'd1);
    chk({tag, "_hs_busy"}, 128'(busy), 128'd0);
    chk({tag, "_hs_data"}, out_data, post_hs(pt));
    @(posedge clk); #1;
    chk({tag, "_single_hs"}, 128'({out_valid, busy}), 128'd0);
  endtask

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

  logic [127:0] pts [8];
  logic [127:0] cts [8];
  logic         seen;
  int           n, acc, prev;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    build_sbox();
    expand_key(KEY_C1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_rk_idx", 128'(rk_idx), 128'd10);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 128'(in_ready), 128'd1);

    do_block("c1", CT_C1, PT_C1, 0);
    expand_key(KEY_B);
    do_block("appb", CT_B, PT_B, 0);
    expand_key(KEY_C1);
    do_block("bp", CT_C1, PT_C1, 20);

    // Abort a block partway through with reset
    in_data = CT_C1; in_valid = 1'b1;
    wait_ready("mid");
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_rk_idx", 128'(rk_idx), 128'd10);
    chk("mid_rst_data", out_data, 128'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("mid_no_valid", 128'(seen), 128'd0);
    chk("mid_in_ready", 128'(in_ready), 128'd1);
    do_block("mid_c1", CT_C1, PT_C1, 0);

    // Back-to-back random blocks under a random key
    expand_key({$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 8; i++) begin
      pts[i] = {$urandom, $urandom, $urandom, $urandom};
      cts[i] = encrypt(pts[i]);
    end
    in_valid = 1'b1; in_data = cts[0]; out_ready = 1'b1; prev = 0;
    for (int i = 0; i < 8; i++) begin
      wait_ready("b2b");
      @(posedge clk); #1;
      acc = cyc;
      if (i > 0) chk("b2b_spacing", 128'(acc - prev), 128'd12);
      prev = acc;
      if (i < 7) in_data = cts[i + 1];
      else in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 30) begin @(posedge clk); #1; n++; end
      chk("b2b_latency", 128'(n), 128'd10);
      chk("b2b_data", out_data, pts[i]);
      @(posedge clk); #1;
      chk("b2b_hs_valid", 128'(out_valid), 128'd0);
      chk("b2b_between", out_data, post_hs(pts[i]));
    end
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
